sixteen_bit_alu: RTL and testbench

Registered 16-bit ALU with 16 operations selected by a 4-bit function code: arithmetic, bitwise logic, unsigned compare, and single-bit shift. It sits in the datapath as a single-cycle-latency execution unit. Operands and function code are sampled on the rising clock edge. Result and category flags are presented from output registers.

---
 rtl/sixteen_bit_alu_pkg.sv | 43 ++++
 rtl/alu_arith_unit.sv | 62 ++++++
 rtl/sixteen_bit_alu.sv | 81 ++++++++
 tb/tb_sixteen_bit_alu.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sixteen_bit_alu_pkg.sv
// Shared definitions for the 16-bit registered ALU: width, opcodes, category decode.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a. MUL/DIV category membership depends on macro ALU_MULDIV_EN.
package sixteen_bit_alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_EQ   = 4'b1010;
  localparam logic [3:0] OP_GT   = 4'b1011;
  localparam logic [3:0] OP_LT   = 4'b1100;
  localparam logic [3:0] OP_SHR  = 4'b1101;
  localparam logic [3:0] OP_SHL  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  // Category flags as {arith, logic, cmp, shift}; at most one bit set.
  // Without the multiplier/divider, MUL and DIV codes act as NOP and carry no category.
  function automatic logic [3:0] cat_decode(input logic [3:0] fun);
    logic [3:0] cat;
    cat = 4'b0000;
    case (fun)
      OP_ADD, OP_SUB: cat = 4'b1000;
`ifdef ALU_MULDIV_EN
      OP_MUL, OP_DIV: cat = 4'b1000;
`endif
      OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR: cat = 4'b0100;
      OP_EQ, OP_GT, OP_LT: cat = 4'b0010;
      OP_SHR, OP_SHL: cat = 4'b0001;
      default: cat = 4'b0000;
    endcase
    return cat;
  endfunction

endpackage

// File: rtl/alu_arith_unit.sv
// Combinational ADD/SUB (and MUL/DIV when ALU_MULDIV_EN is defined) with carry/borrow/overflow.
// Latency: 0 cycles (pure combinational; registered by the parent).
// Backpressure: none; result is valid whenever inputs are.
module alu_arith_unit
  import sixteen_bit_alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit 16 of the 17-bit difference is set exactly when a < b (borrow).
  assign diff = {1'b0, a} - {1'b0, b};

`ifdef ALU_MULDIV_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

  // Select the arithmetic result and its carry; non-arithmetic codes yield zero.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        result = prod[DATA_W-1:0];
        carry  = |prod[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        // Divide-by-zero returns zero and raises carry instead of an undefined quotient.
        if (b == '0) begin
          result = '0;
          carry  = 1'b1;
        end else begin
          result = a / b;
          carry  = 1'b0;
        end
      end
`endif
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sixteen_bit_alu.sv
// Registered 16-bit ALU: arithmetic, bitwise logic, unsigned compare, 1-bit shift; MUL/DIV gated by ALU_MULDIV_EN.
// Latency: 1 cycle, result and flags change only on the rising edge of clk.
// Backpressure: none; a new operation is accepted every cycle.
module sixteen_bit_alu
  import sixteen_bit_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        ALU_FUN,
  output logic [DATA_W-1:0] ALU_OUT,
  output logic              Carry_flag,
  output logic              Arith_flag,
  output logic              Logic_flag,
  output logic              CMP_flag,
  output logic              Shift_flag
);

  logic [DATA_W-1:0] arith_res;
  logic              arith_carry;
  logic [DATA_W-1:0] nxt_out;
  logic              nxt_carry;
  logic [3:0]        nxt_cat;

  alu_arith_unit u_arith (
    .a      (A),
    .b      (B),
    .op     (ALU_FUN),
    .result (arith_res),
    .carry  (arith_carry)
  );

  // Next-state result mux; carry only propagates from the arithmetic unit.
  always_comb begin
    nxt_out   = '0;
    nxt_carry = 1'b0;
    nxt_cat   = cat_decode(ALU_FUN);
    case (ALU_FUN)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        nxt_out   = arith_res;
        nxt_carry = arith_carry;
      end
      OP_AND:  nxt_out = A & B;
      OP_OR:   nxt_out = A | B;
      OP_NAND: nxt_out = ~(A & B);
      OP_NOR:  nxt_out = ~(A | B);
      OP_XOR:  nxt_out = A ^ B;
      OP_XNOR: nxt_out = ~(A ^ B);
      OP_EQ:   nxt_out = {{(DATA_W-1){1'b0}}, (A == B)};
      OP_GT:   nxt_out = {{(DATA_W-1){1'b0}}, (A > B)};
      OP_LT:   nxt_out = {{(DATA_W-1){1'b0}}, (A < B)};
      OP_SHR:  nxt_out = {1'b0, A[DATA_W-1:1]};
      OP_SHL:  nxt_out = {A[DATA_W-2:0], 1'b0};
      default: begin
        nxt_out   = '0;
        nxt_carry = 1'b0;
      end
    endcase
  end

  // Output register with synchronous reset taking priority over any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALU_OUT    <= '0;
      Carry_flag <= 1'b0;
      Arith_flag <= 1'b0;
      Logic_flag <= 1'b0;
      CMP_flag   <= 1'b0;
      Shift_flag <= 1'b0;
    end else begin
      ALU_OUT    <= nxt_out;
      Carry_flag <= nxt_carry;
      Arith_flag <= nxt_cat[3];
      Logic_flag <= nxt_cat[2];
      CMP_flag   <= nxt_cat[1];
      Shift_flag <= nxt_cat[0];
    end
  end

endmodule

// File: tb/tb_sixteen_bit_alu.sv
// Directed table-driven bench for sixteen_bit_alu plus reset and latency sequences.
// Latency: expects results one rising edge after inputs are applied.
// Backpressure: none; ALU_MULDIV_EN selects MUL/DIV expectations.
module tb_sixteen_bit_alu;
  import sixteen_bit_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        Carry_flag, Arith_flag, Logic_flag, CMP_flag, Shift_flag;

  int total;
  int bad;

  sixteen_bit_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .ALU_OUT    (ALU_OUT),
    .Carry_flag (Carry_flag),
    .Arith_flag (Arith_flag),
    .Logic_flag (Logic_flag),
    .CMP_flag   (CMP_flag),
    .Shift_flag (Shift_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags packed as {carry, arith, logic, cmp, shift}.
  typedef struct {
    logic [3:0]  fun;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic [4:0]  exp_flags;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] o, input logic [4:0] fl);
    vec_t v;
    v.fun = f; v.a = a; v.b = b; v.exp_out = o; v.exp_flags = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] exp_out, input logic [4:0] exp_flags);
    logic [4:0] act_flags;
    act_flags = {Carry_flag, Arith_flag, Logic_flag, CMP_flag, Shift_flag};
    total++;
    if (ALU_OUT !== exp_out || act_flags !== exp_flags) begin
      bad++;
      $display("FAIL %s: got out=%h flags=%b, want out=%h flags=%b",
               name, ALU_OUT, act_flags, exp_out, exp_flags);
    end
  endtask

  task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    ALU_FUN = f; A = a; B = b;
  endtask

  // Drive, clock once, then sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = mk(OP_ADD,  16'h0015, 16'h0025, 16'h003A, 5'b01000);
    vecs[1]  = mk(OP_ADD,  16'h8000, 16'h8000, 16'h0000, 5'b11000);
    vecs[2]  = mk(OP_SUB,  16'h0005, 16'h0003, 16'h0002, 5'b01000);
    vecs[3]  = mk(OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 5'b11000);
`ifdef ALU_MULDIV_EN
    vecs[4]  = mk(OP_MUL,  16'h0004, 16'h0003, 16'h000C, 5'b01000);
    vecs[5]  = mk(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 5'b11000);
    vecs[6]  = mk(OP_DIV,  16'h0010, 16'h0004, 16'h0004, 5'b01000);
    vecs[7]  = mk(OP_DIV,  16'h1234, 16'h0000, 16'h0000, 5'b11000);
`else
    vecs[4]  = mk(OP_MUL,  16'h0004, 16'h0003, 16'h0000, 5'b00000);
    vecs[5]  = mk(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 5'b00000);
    vecs[6]  = mk(OP_DIV,  16'h0010, 16'h0004, 16'h0000, 5'b00000);
    vecs[7]  = mk(OP_DIV,  16'h1234, 16'h0000, 16'h0000, 5'b00000);
`endif
    vecs[8]  = mk(OP_AND,  16'h00FF, 16'h0F0F, 16'h000F, 5'b00100);
    vecs[9]  = mk(OP_OR,   16'h00FF, 16'h0F0F, 16'h0FFF, 5'b00100);
    vecs[10] = mk(OP_NAND, 16'h00FF, 16'h0F0F, 16'hFFF0, 5'b00100);
    vecs[11] = mk(OP_NOR,  16'h00FF, 16'h0F0F, 16'hF000, 5'b00100);
    vecs[12] = mk(OP_XOR,  16'h00FF, 16'h0F0F, 16'h0FF0, 5'b00100);
    vecs[13] = mk(OP_XNOR, 16'h00FF, 16'h0F0F, 16'hF00F, 5'b00100);
    vecs[14] = mk(OP_EQ,   16'h00FF, 16'h00FF, 16'h0001, 5'b00010);
    vecs[15] = mk(OP_EQ,   16'h00FF, 16'h00FE, 16'h0000, 5'b00010);
    vecs[16] = mk(OP_GT,   16'h0100, 16'h00FF, 16'h0001, 5'b00010);
    vecs[17] = mk(OP_GT,   16'h00FF, 16'h0100, 16'h0000, 5'b00010);
    vecs[18] = mk(OP_LT,   16'h00FF, 16'h0100, 16'h0001, 5'b00010);
    vecs[19] = mk(OP_LT,   16'h00FF, 16'h00FF, 16'h0000, 5'b00010);
    vecs[20] = mk(OP_SHR,  16'h00FF, 16'hFFFF, 16'h007F, 5'b00001);
    vecs[21] = mk(OP_SHL,  16'h00FF, 16'hFFFF, 16'h01FE, 5'b00001);
    vecs[22] = mk(OP_SHL,  16'h8001, 16'h0000, 16'h0002, 5'b00001);
    vecs[23] = mk(OP_NOP,  16'hFFFF, 16'hFFFF, 16'h0000, 5'b00000);

    // Reset held two cycles with a carrying ADD pending.
    rst_n = 1'b0;
    drive(OP_ADD, 16'hFFFF, 16'hFFFF);
    step();
    check("reset_cyc1", 16'h0000, 5'b00000);
    step();
    check("reset_cyc2", 16'h0000, 5'b00000);

    // First edge after release registers the pending ADD.
    rst_n = 1'b1;
    step();
    check("reset_release_add", 16'hFFFE, 5'b11000);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].fun, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_flags);
    end

    // Back-to-back ADD then AND; input change between edges must not disturb outputs.
    drive(OP_ADD, 16'h0015, 16'h0025);
    step();
    check("b2b_add", 16'h003A, 5'b01000);
    drive(OP_AND, 16'h00FF, 16'h0F0F);
    #2;
    check("b2b_hold_before_edge", 16'h003A, 5'b01000);
    step();
    check("b2b_and", 16'h000F, 5'b00100);

    // Reset overrides a live operation, then recovery registers it normally.
    drive(OP_SHL, 16'h4000, 16'h0000);
    rst_n = 1'b0;
    step();
    check("reset_override", 16'h0000, 5'b00000);
    rst_n = 1'b1;
    step();
    check("recovery_shl", 16'h8000, 5'b00001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
